multiport_memory: RTL
=====================

Name: multiport_memory

Overview:
- Parametrised memory with one shared write port and READ_PORTS independent synchronous read ports.
- Each read port has its own replicated storage bank, and all banks receive every write.
- Adds per-port read enable/valid, read-during-write bypass, range checking and a post-reset clear sequencer.
- Sits between the CPU core and instruction/data/stack memory spaces.

Parameters:
- DATA_WIDTH, 16, bits per word.
- ADDRESS_WIDTH, 17, bits per address (shared by all ports).
- WORDS, 81920, implemented depth; must satisfy WORDS <= 2**ADDRESS_WIDTH.
- READ_PORTS, 3, number of read ports (1..8).
- CLEAR_ON_RESET, 1, when 1, zero all words after reset before accepting traffic.
- BYPASS, 1, when 1, a same-cycle write to the read address forwards data_in to that read.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- write_enable  input  1  write request, honoured only while write_ready=1.
- write_address  input  ADDRESS_WIDTH  write address.
- data_in  input  DATA_WIDTH  write data.
- write_ready  output  1  memory accepting writes.
- read_enable  input  READ_PORTS  per-port read request.
- read_address  input  READ_PORTS*ADDRESS_WIDTH  flattened; port i at [i*AW +: AW].
- data_out  output  READ_PORTS*DATA_WIDTH  flattened; port i at [i*DW +: DW].
- read_valid  output  READ_PORTS  per-port data_out valid strobe.
- range_error  output  READ_PORTS+1  sticky out-of-range flags; bit READ_PORTS = write port.
- init_done  output  1  clear sequence finished.

Behaviour:
- Reset asserted (reset=0): data_out=0, read_valid=0, range_error=0, write_ready=0, init_done=0, clear counter=0. Takes effect immediately.
- States: RESET, CLEAR, RUN.
- Reset release goes to CLEAR if CLEAR_ON_RESET=1, otherwise RUN on the first rising edge.
- CLEAR:
  - Writes 0 to address counter value in all banks, one word per cycle, counter 0..WORDS-1.
  - After writing WORDS-1, moves to RUN, so CLEAR lasts exactly WORDS cycles.
  - write_enable and read_enable are ignored; read_valid stays 0.
- RUN: write_ready=1 and init_done=1, registered, so both are high on the first RUN cycle.
- Write: in RUN, write_enable=1 with write_address < WORDS writes data_in to all banks at that edge.
- Read: latency 1. read_enable[i]=1 at edge k gives data_out slice i = mem[addr] and read_valid[i]=1 after edge k.
  - read_valid[i] is a one-cycle strobe per request; back-to-back requests give one result per cycle.
  - With read_enable[i]=0, read_valid[i]=0 and data_out slice i holds its last value.
- Simultaneous write and read of the same address on the same edge:
  - BYPASS=1: read returns the new data_in.
  - BYPASS=0: read returns the old contents.
  - The write always commits.
- Reads on different ports to the same address are independent and return identical data.
- Out of range (address >= WORDS):
  - Write: ignored, sets range_error[READ_PORTS].
  - Read on port i: returns 0 with read_valid[i]=1, sets range_error[i].
  - Flags clear only on reset.
- Reset during CLEAR: restarts CLEAR from address 0 after release.
- Reset during RUN: memory contents are undefined if CLEAR_ON_RESET=0.
- Address comparison is unsigned over full ADDRESS_WIDTH bits; no address wrap.

Decomposition:
- Shared package `memory_pkg`:
  - state encoding (RESET, CLEAR, RUN);
  - helper function for flattened slice offsets;
  - default DATA_WIDTH and ADDRESS_WIDTH constants.
- Sub-module `memory_bank`:
  - one simple dual-port RAM (one write, one registered read), parametrised WORDS, DATA_WIDTH, ADDRESS_WIDTH;
  - instantiated READ_PORTS times in a generate loop.
- Clear sequencer, bypass muxes and range checks live in the top-level `multiport_memory`.

Test Plan:
- Clear, with WORDS=16, READ_PORTS=3: release reset → write_ready rises exactly 16 cycles later; reading all 16 addresses on every port returns 0x0000.
- Basic read/write: write 0xBEEF to address 5; next cycle read address 5 on ports 0,1,2 → all return 0xBEEF with read_valid=3'b111 one cycle after the request.
- Read-during-write: address 7 holds 0x1111; write 0x2222 to 7 while port 1 reads 7. BYPASS=1 → 0x2222; BYPASS=0 → 0x1111; a following read → 0x2222 in both.
- Range: with WORDS=16, write address 20 and read address 17 on port 2 → range_error=4'b1100, port 2 data 0, no bank modified; flags persist until reset.
- Reset mid-clear: pull reset low at clear count 9 → all outputs 0 immediately; after release, 16 full clear cycles are required before write_ready=1.
- Idle hold: read 0xBEEF on port 0, then drop read_enable for 5 cycles while writing other addresses → data_out port 0 stays 0xBEEF and read_valid[0]=0.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared definitions for the multiport memory slice.
//   state_t      : controller states (reset hold, post-reset clear, normal run)
//   read_sel_t   : source of each read port's output word
//   slice_lo()   : low bit of element 'index' in a flattened bus of 'width'-bit elements
package memory_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 16;
  localparam int DEFAULT_ADDRESS_WIDTH = 17;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    SEL_BANK,    // word read from the port's bank
    SEL_BYPASS,  // word forwarded from a same-edge write
    SEL_ZERO     // out-of-range read returns zero
  } read_sel_t;

  function automatic int slice_lo(input int index, input int width);
    return index * width;
  endfunction

endpackage

// File: rtl/memory_bank.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clock, reset                : clock and async active-low reset (output register only)
//   write_enable/address/data_in: synchronous write
//   read_enable/read_address    : synchronous read request
//   data_out                    : registered read word, held while read_enable=0
// A read and write to the same address on the same edge returns the old word.
module memory_bank
  import memory_pkg::*;
#(
  parameter int WORDS         = 16,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0]    data_out
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // NOTE: the storage array has no reset so it maps onto block RAM; clearing
  // it is the job of the sequencer in the top level.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_address] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so this read sees
  // the pre-write contents when both ports hit the same word on one edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (read_enable) begin
      data_out <= mem[read_address];
    end
  end

endmodule

// File: rtl/multiport_memory.sv
// Memory with one shared write port and READ_PORTS synchronous read ports.
// Each read port owns a replicated bank; every write goes to all banks.
//   clock, reset        : clock and async active-low reset
//   write_enable/address/data_in, write_ready : shared write port
//   read_enable, read_address, data_out, read_valid : per-port reads (flattened)
//   range_error         : sticky out-of-range flags, bit READ_PORTS = write port
//   init_done           : post-reset clear finished
module multiport_memory
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
  parameter int WORDS          = 81920,
  parameter int READ_PORTS     = 3,
  parameter int CLEAR_ON_RESET = 1,
  parameter int BYPASS         = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                write_enable,
  input  logic [ADDRESS_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH-1:0]               data_in,
  output logic                                write_ready,
  input  logic [READ_PORTS-1:0]               read_enable,
  input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0]    data_out,
  output logic [READ_PORTS-1:0]               read_valid,
  output logic [READ_PORTS:0]                 range_error,
  output logic                                init_done
);

  // Banks are indexed with only the bits needed for WORDS; the range check
  // below guarantees the dropped upper bits are zero whenever a bank is used.
  localparam int INDEX_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDRESS_WIDTH:0]   WORDS_EXT = (ADDRESS_WIDTH + 1)'(WORDS);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(WORDS - 1);

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] clear_count;
  logic                     ready_q;
  logic                     write_error_q;

  // ---------------- controller ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_RESET;
      clear_count <= '0;
      ready_q     <= 1'b0;
    end else begin
      state       <= state_next;
      clear_count <= (state == ST_CLEAR) ? clear_count + 1'b1 : '0;
      // Registered from next state so the flag is already high in the first RUN cycle.
      ready_q     <= (state_next == ST_RUN);
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RESET: state_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      ST_CLEAR: if (clear_count == LAST_ADDR) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_RESET;
    endcase
  end

  assign write_ready = ready_q;
  assign init_done   = ready_q;

  // ---------------- shared write path ----------------
  logic                   running, clearing, write_in_range, write_commit;
  logic                   bank_we;
  logic [INDEX_WIDTH-1:0] bank_waddr;
  logic [DATA_WIDTH-1:0]  bank_wdata;

  assign running        = (state == ST_RUN);
  assign clearing       = (state == ST_CLEAR);
  assign write_in_range = ({1'b0, write_address} < WORDS_EXT);
  assign write_commit   = running && write_enable && write_in_range;

  assign bank_we    = write_commit || clearing;
  assign bank_waddr = clearing ? clear_count[INDEX_WIDTH-1:0] : write_address[INDEX_WIDTH-1:0];
  assign bank_wdata = clearing ? '0 : data_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_error_q <= 1'b0;
    end else if (running && write_enable && !write_in_range) begin
      write_error_q <= 1'b1;
    end
  end

  assign range_error[READ_PORTS] = write_error_q;

  // ---------------- read ports ----------------
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     in_range, request, hit;
    logic [DATA_WIDTH-1:0]    bank_q, bypass_q, word;
    read_sel_t                sel_q;
    logic                     valid_q, error_q;

    assign addr     = read_address[slice_lo(p, ADDRESS_WIDTH) +: ADDRESS_WIDTH];
    assign in_range = ({1'b0, addr} < WORDS_EXT);
    assign request  = running && read_enable[p];
    assign hit      = (BYPASS != 0) && write_commit && (write_address == addr);

    memory_bank #(
      .WORDS         (WORDS),
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (INDEX_WIDTH)
    ) u_bank (
      .clock         (clock),
      .reset         (reset),
      .write_enable  (bank_we),
      .write_address (bank_waddr),
      .data_in       (bank_wdata),
      .read_enable   (request && in_range),
      .read_address  (addr[INDEX_WIDTH-1:0]),
      .data_out      (bank_q)
    );

    // The bank output and the selector only change on a request, so the
    // port's output word holds between requests.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sel_q    <= SEL_BANK;
        bypass_q <= '0;
        valid_q  <= 1'b0;
        error_q  <= 1'b0;
      end else begin
        valid_q <= request;
        if (request) begin
          if (!in_range) begin
            sel_q   <= SEL_ZERO;
            error_q <= 1'b1;
          end else if (hit) begin
            sel_q    <= SEL_BYPASS;
            bypass_q <= data_in;
          end else begin
            sel_q <= SEL_BANK;
          end
        end
      end
    end

    always_comb begin
      word = bank_q;
      unique case (sel_q)
        SEL_ZERO:   word = '0;
        SEL_BYPASS: word = bypass_q;
        default:    word = bank_q;
      endcase
    end

    assign data_out[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = word;
    assign read_valid[p]  = valid_q;
    assign range_error[p] = error_q;
  end

endmodule
